acc_cpu_core: RTL

ACC_CPU_CORE -- requirements
Module: acc_cpu_core

---
 rtl/acc_cpu_core.sv | 104 ++++++++++
 1 files changed

// File: rtl/acc_cpu_core.sv
// acc_cpu_core: multi-cycle accumulator CPU with a single req/ack memory port.
// Define ACC_CPU_IMM_EN to execute immediate forms; otherwise flagged instructions trap as illegal.
module acc_cpu_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET = 'h100,
  parameter int PC_STEP = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ac,
  output logic                  halted,
  output logic                  illegal,
  output logic                  retire
);
  localparam int OW = DATA_WIDTH - 5;
  typedef enum logic [1:0] {FETCH, DECODE, OPER, HALT} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] ir, alu_b, alu_res, ac_n;
  logic [ADDR_WIDTH-1:0] opnd_addr, pc_inc;
  logic [3:0] op;
  logic flag, pend, is_mem, is_reg, is_imm, is_halt, done, skip_t, fetch_go;
  assign flag = ir[DATA_WIDTH-1];
  assign op = ir[DATA_WIDTH-2:DATA_WIDTH-5];
  assign opnd_addr = ADDR_WIDTH'(ir[OW-1:0]);
  assign pc_inc = pc + ADDR_WIDTH'(PC_STEP);
  assign is_mem = !flag && op inside {4'd0, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9};
  assign is_reg = !flag && op inside {4'd4, 4'd5, 4'd6, 4'd10};
  assign is_halt = !flag && op == 4'd1;
`ifdef ACC_CPU_IMM_EN
  assign is_imm = flag && op inside {4'd0, 4'd7, 4'd8, 4'd9};
  assign alu_b = state == OPER ? mem_rdata : DATA_WIDTH'(ir[OW-1:0]);
`else
  assign is_imm = 1'b0;
  assign alu_b = mem_rdata;
`endif
  assign done = is_reg || is_imm;
  assign skip_t = ir[11:10] == 2'b00 ? ac[DATA_WIDTH-1] :
                  ir[11:10] == 2'b01 ? ac == '0 :
                  ir[11:10] == 2'b10 ? !ac[DATA_WIDTH-1] && ac != '0 : 1'b0;
  assign alu_res = op == 4'd0 ? ac + alu_b : op == 4'd7 ? ac - alu_b :
                   op == 4'd8 ? ac & alu_b : op == 4'd9 ? ac | alu_b : alu_b;
  assign ac_n = state == OPER ? (op == 4'd3 ? ac : alu_res) :
                op == 4'd4 ? '0 : op == 4'd10 ? ~ac : is_imm ? alu_res : ac;
  // a fetch already on the bus keeps its request up even if run drops
  assign fetch_go = run || pend;
  assign mem_wdata = ac;
  always_comb begin
    state_n = state;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = pc;
    case (state)
      FETCH: begin
        mem_req = fetch_go;
        state_n = fetch_go && mem_ack ? DECODE : FETCH;
      end
      DECODE: state_n = is_mem ? OPER : done ? FETCH : HALT;
      OPER: begin
        mem_req = 1'b1;
        mem_we = op == 4'd3;
        mem_addr = opnd_addr;
        state_n = mem_ack ? FETCH : OPER;
      end
      default: state_n = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= PC_RESET;
      ac <= '0;
      ir <= '0;
      halted <= 1'b0;
      illegal <= 1'b0;
      retire <= 1'b0;
      pend <= 1'b0;
    end else begin
      state <= state_n;
      pend <= state == FETCH && mem_req && !mem_ack;
      retire <= (state == DECODE && done) || (state == OPER && mem_ack);
      if (state == FETCH && mem_req && mem_ack) begin
        ir <= mem_rdata;
        pc <= pc_inc;
      end
      if (state == DECODE && is_reg)
        pc <= op == 4'd6 ? opnd_addr : op == 4'd5 && skip_t ? pc_inc : pc;
      if ((state == DECODE && done) || (state == OPER && mem_ack))
        ac <= ac_n;
      if (state == DECODE && !is_mem && !done) begin
        halted <= 1'b1;
        illegal <= !is_halt;
      end
    end
  end
endmodule
